// File: rtl/computer_pkg.sv
// Shared definitions for the teaching-computer datapath: instruction opcodes and bus-source selection.
package computer_pkg;

  localparam logic [7:0] NOP = 8'h00;
  localparam logic [7:0] LDA = 8'h10;
  localparam logic [7:0] ADD = 8'h20;
  localparam logic [7:0] SUB = 8'h30;
  localparam logic [7:0] STA = 8'h40;
  localparam logic [7:0] LDI = 8'h50;
  localparam logic [7:0] JMP = 8'h60;
  localparam logic [7:0] JC  = 8'h70;
  localparam logic [7:0] JZ  = 8'h80;
  localparam logic [7:0] OUT = 8'hE0;
  localparam logic [7:0] HLT = 8'hF0;

  typedef enum logic [1:0] {
    SRC_SW,
    SRC_A,
    SRC_ALU,
    SRC_RAM
  } bus_src_e;

  // Program mode hands the bus to the switches; in run mode A beats the ALU, RAM is the fallback.
  function automatic bus_src_e sel_bus_src(input logic prog, input logic ao, input logic eo);
    if (!prog)   return SRC_SW;
    else if (ao) return SRC_A;
    else if (eo) return SRC_ALU;
    else         return SRC_RAM;
  endfunction

endpackage

// File: rtl/computer_sn74x189.sv
// 16x4 SRAM slice modelled on the 74189: transparent level-sensitive write, inverted tri-state read.
module sn74x189 (
  input  logic [3:0] a,
  input  logic [3:0] d,
  input  logic       cs_,
  input  logic       we_,
  output logic [3:0] o_
);

  // NOTE: storage arrays carry no reset; contents survive clr and power up undefined.
  logic [3:0] mem [16];

  // NOTE: this latch is intentional -- the part is transparent for as long as cs_ and we_ are low.
  always_latch begin
    if (!cs_ && !we_) mem[a] <= d;
  end

  assign o_ = (!cs_ && we_) ? ~mem[a] : 4'bz;

endmodule

// File: rtl/computer.sv
// Datapath of a minimal bus-based teaching computer (A, B, ALU, flags, MAR, 16-word RAM).
// Optional simulation check for bus/flag misuse: define COMPUTER_CONTENTION_CHK_EN.
module computer
  import computer_pkg::*;
#(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] sw_dat,
  input  logic [A-1:0] sw_mar,
  input  logic         prog,
  input  logic         ai,
  input  logic         ao,
  input  logic         bi,
  input  logic         fi,
  input  logic         eo,
  input  logic         su,
  output logic [N-1:0] aval,
  output logic [N-1:0] bval,
  output logic [N-1:0] aluval,
  output logic [N-1:0] bus,
  output logic [A-1:0] marval,
  output logic         cf,
  output logic         zf
);

  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [A-1:0] mar_q, mar_d;
  logic         cf_q, cf_d, zf_q, zf_d;
  logic [N:0]   alu_sum;
  logic [N-1:0] ram_o_, ram_rd;
  logic [A-1:0] ram_addr;
  logic         ram_we_;

  // Subtraction is A + ~B + 1, so the carry out reads as "no borrow".
  always_comb begin
    alu_sum = {1'b0, a_q} + {1'b0, (su ? ~b_q : b_q)} + (N + 1)'(su);
  end

  // The write strobe is the high phase of clk in program mode; switches must be stable while clk is high.
  assign ram_we_  = ~(~prog & clk);
  assign ram_addr = prog ? mar_q : sw_mar;

  for (genvar g = 0; g < N / 4; g++) begin : g_ram
    sn74x189 u_slice (
      .a   (ram_addr),
      .d   (sw_dat[4*g +: 4]),
      .cs_ (1'b0),
      .we_ (ram_we_),
      .o_  (ram_o_[4*g +: 4])
    );
  end

  assign ram_rd = ~ram_o_;

  always_comb begin
    bus = ram_rd;
    unique case (sel_bus_src(prog, ao, eo))
      SRC_SW:  bus = sw_dat;
      SRC_A:   bus = a_q;
      SRC_ALU: bus = alu_sum[N-1:0];
      SRC_RAM: bus = ram_rd;
      default: bus = ram_rd;
    endcase
  end

  always_comb begin
    a_d   = ai ? bus : a_q;
    b_d   = bi ? bus : b_q;
    mar_d = prog ? mar_q : sw_mar;
    cf_d  = fi ? alu_sum[N] : cf_q;
    zf_d  = fi ? (alu_sum[N-1:0] == '0) : zf_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_q   <= '0;
      b_q   <= '0;
      mar_q <= '0;
      cf_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      mar_q <= mar_d;
      cf_q  <= cf_d;
      zf_q  <= zf_d;
    end
  end

  assign aval   = a_q;
  assign bval   = b_q;
  assign aluval = alu_sum[N-1:0];
  assign marval = mar_q;
  assign cf     = cf_q;
  assign zf     = zf_q;

`ifdef COMPUTER_CONTENTION_CHK_EN
  bus_contention_chk : assert property (@(posedge clk) disable iff (clr) !(prog && ao && eo))
    else $error("bus contention: ao and eo both asserted in run mode");
  flag_su_chk : assert property (@(posedge clk) disable iff (clr) fi |-> $stable(su))
    else $error("su changed on a flag-load edge");
`else
  // Without the check, ao-over-eo priority in the bus mux settles any conflict.
`endif

endmodule

// File: tb/tb_computer.sv
// Directed-vector bench for the computer datapath; inputs change in the low clock phase.
module tb_computer;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] sw_dat;
  logic [3:0] sw_mar;
  logic       prog, ai, ao, bi, fi, eo, su;
  logic [7:0] aval, bval, aluval, bus;
  logic [3:0] marval;
  logic       cf, zf;

  int vectors = 0;
  int miscompares = 0;

  computer #(.N(8), .A(4)) dut (
    .clk    (clk),
    .clr    (clr),
    .sw_dat (sw_dat),
    .sw_mar (sw_mar),
    .prog   (prog),
    .ai     (ai),
    .ao     (ao),
    .bi     (bi),
    .fi     (fi),
    .eo     (eo),
    .su     (su),
    .aval   (aval),
    .bval   (bval),
    .aluval (aluval),
    .bus    (bus),
    .marval (marval),
    .cf     (cf),
    .zf     (zf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return in the low phase so the next drive cannot disturb a RAM write.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic strobes_off();
    ai = 0; ao = 0; bi = 0; fi = 0; eo = 0;
  endtask

  typedef struct { logic [3:0] addr; logic [7:0] data; } wr_t;
  wr_t prog_tbl[5] = '{'{4'd0, 8'h1E}, '{4'd1, 8'h2F}, '{4'd2, 8'hE0},
                       '{4'd15, 8'h05}, '{4'd14, 8'h07}};

  initial begin
    clr = 1; prog = 0; sw_dat = 0; sw_mar = 0; su = 0;
    strobes_off();
    #1;
    check("rst_a", aval, 0);
    check("rst_b", bval, 0);
    check("rst_mar", marval, 0);
    check("rst_cf", cf, 0);
    check("rst_zf", zf, 0);
    @(negedge clk);
    clr = 0;
    #1;

    // Program load through the switches.
    foreach (prog_tbl[i]) begin
      sw_mar = prog_tbl[i].addr;
      sw_dat = prog_tbl[i].data;
      #1;
      check($sformatf("load_bus%0d", i), bus, prog_tbl[i].data);
      tick();
      check($sformatf("load_mar%0d", i), marval, prog_tbl[i].addr);
    end

    // Readback from RAM[14] in run mode, then load A from it.
    prog = 1; sw_dat = 8'hAA; sw_mar = 4'd9;
    #1;
    check("rd_bus14", bus, 8'h07);
    ai = 1;
    tick();
    ai = 0;
    check("rd_a", aval, 8'h07);
    check("rd_mar_hold", marval, 4'd14);

    // B <= 05 from the switches (also rewrites RAM[15] with the same value).
    prog = 0; sw_mar = 4'd15; sw_dat = 8'h05; bi = 1;
    tick();
    bi = 0;
    check("ld_b", bval, 8'h05);

    // Add 07 + 05.
    prog = 1; su = 0; eo = 1; fi = 1;
    #1;
    check("add_alu", aluval, 8'h0C);
    check("add_bus", bus, 8'h0C);
    tick();
    strobes_off();
    check("add_cf", cf, 0);
    check("add_zf", zf, 0);
    check("add_a_hold", aval, 8'h07);

    // A <= RAM[15]=05, presetting su for the subtract.
    su = 1;
    #1;
    check("ram15_bus", bus, 8'h05);
    ai = 1;
    tick();
    ai = 0;
    check("ld_a05", aval, 8'h05);
    fi = 1;
    #1;
    check("sub_alu", aluval, 8'h00);
    tick();
    fi = 0;
    check("sub_cf", cf, 1);
    check("sub_zf", zf, 1);

    // Flags hold without fi.
    su = 0;
    tick();
    check("hold_alu", aluval, 8'h0A);
    check("hold_cf", cf, 1);
    check("hold_zf", zf, 1);
    fi = 1;
    tick();
    fi = 0;
    check("add0a_cf", cf, 0);
    check("add0a_zf", zf, 0);

    // Wrap: A=FF, B=01 loaded in program mode.
    prog = 0; sw_mar = 4'd3; sw_dat = 8'hFF; ai = 1;
    tick();
    ai = 0; sw_dat = 8'h01; bi = 1;
    tick();
    bi = 0; prog = 1; fi = 1;
    #1;
    check("wrap_alu", aluval, 8'h00);
    tick();
    fi = 0;
    check("wrap_cf", cf, 1);
    check("wrap_zf", zf, 1);

    // Bus priority: ao over eo (no clock edge while both are high).
    ao = 1; eo = 1;
    #1;
    check("prio_bus", bus, 8'hFF);
    ao = 0;
    #1;
    check("eo_bus", bus, 8'h00);

    // Read-modify-write A <= A + B, then A <= A - B.
    ai = 1;
    tick();
    check("rmw_add_a", aval, 8'h00);
    su = 1; ai = 0; eo = 0;
    tick();
    check("sub_borrow_alu", aluval, 8'hFF);
    ai = 1; eo = 1; fi = 1;
    tick();
    strobes_off();
    check("rmw_sub_a", aval, 8'hFF);
    check("borrow_cf", cf, 0);
    check("borrow_zf", zf, 0);

    // ai and bi together load both registers.
    prog = 0; sw_mar = 4'd3; sw_dat = 8'h3C; ai = 1; bi = 1;
    tick();
    strobes_off();
    check("dual_a", aval, 8'h3C);
    check("dual_b", bval, 8'h3C);
    prog = 1; fi = 1;
    tick();
    fi = 0;
    check("pre_rst_cf", cf, 1);

    // Asynchronous clear mid low phase, RAM survives.
    clr = 1;
    #1;
    check("arst_a", aval, 0);
    check("arst_b", bval, 0);
    check("arst_mar", marval, 0);
    check("arst_cf", cf, 0);
    check("arst_zf", zf, 0);
    clr = 0;
    #1;
    check("ram0_kept", bus, 8'h1E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/computer.md
Name: computer

Overview:
- 8-bit datapath of a minimal teaching computer: a shared bus links the A register, B register, add/subtract ALU, flags register, memory address register (MAR) and a 16-word RAM.
- The RAM is built from 16x4 inverting-output SRAM slices.
- Control strobes come from the ports; no instruction sequencer is included.
- Switch inputs load the program into RAM while the block is in program mode.

Parameters:
- N, 8, data/bus width in bits; must be a multiple of 4.
- A, 4, address width; must be 4 (RAM depth 16).

Ports:
- clk  in  1  system clock; all registers update on its rising edge.
- clr  in  1  reset, asynchronous, active-high.
- sw_dat  in  N  data switches; drive the bus in program mode.
- sw_mar  in  A  address switches.
- prog  in  1  mode select: 0 = program mode, 1 = run mode.
- ai  in  1  A register loads from bus.
- ao  in  1  A register drives bus.
- bi  in  1  B register loads from bus.
- fi  in  1  flags register loads from ALU.
- eo  in  1  ALU result drives bus.
- su  in  1  ALU subtracts when 1, adds when 0.
- aval  out  N  A register contents.
- bval  out  N  B register contents.
- aluval  out  N  combinational ALU result.
- bus  out  N  current bus value.
- marval  out  A  MAR contents.
- cf  out  1  registered carry flag.
- zf  out  1  registered zero flag.

Behaviour:
- Reset (clr=1, asynchronous):
  - A, B, MAR, cf and zf clear to 0 immediately.
  - RAM contents are not cleared.
- Bus source, combinational, no high-Z on the output:
  - prog=0: bus = sw_dat.
  - prog=1: bus = A if ao; else ALU result if eo; else RAM[marval].
  - ao has priority over eo.
- MAR:
  - On a rising edge with prog=0, marval <= sw_mar.
  - With prog=1, the MAR holds its value.
- RAM write:
  - On a rising edge with prog=0, RAM[sw_mar] <= sw_dat.
  - The address comes from the switches directly, so the write and the MAR load happen on the same edge.
- RAM read: asynchronous; RAM[marval] is visible in the same cycle.
- A register: rising edge with ai=1 gives A <= bus.
- B register: rising edge with bi=1 gives B <= bus.
- ai and bi may be asserted together; both registers load.
- ALU, combinational, width N+1 internally:
  - su=0: {c,r} = A + B.
  - su=1: {c,r} = A + ~B + 1; c=1 means no borrow.
  - aluval = r, truncated to N bits, wrapping modulo 2^N.
- Flags: rising edge with fi=1 gives cf <= c and zf <= (r == 0). Flags hold otherwise.
- Read-modify-write: ai together with eo on the same edge loads A with A±B computed from the pre-edge values.
- Register control strobes are honoured in both modes.

Optional Feature:
- Macro: COMPUTER_CONTENTION_CHK_EN.
- Defined:
  - A simulation-only check reports an $error on any rising edge where prog=1, ao=1 and eo=1.
  - The same check reports an $error if su changes while fi=1 at a clock edge.
- Undefined: no check is compiled; ao-over-eo priority resolves the conflict silently.
- Synthesized logic is identical either way.

Decomposition:
- Shared package computer_pkg holds:
  - Opcode constants: NOP=8'h00, LDA=8'h10, ADD=8'h20, SUB=8'h30, STA=8'h40, LDI=8'h50, JMP=8'h60, JC=8'h70, JZ=8'h80, OUT=8'hE0, HLT=8'hF0.
  - A bus-source enum for program/A/ALU/RAM.
- One natural sub-module, sn74x189: a 16x4 SRAM slice.
  - Ports: a[3:0], d[3:0], cs_, we_, o_[3:0].
  - Write is level-sensitive and transparent while cs_=0 and we_=0.
  - Outputs are the inverted stored data when cs_=0 and we_=1; high-Z otherwise.
- The RAM uses N/4 sn74x189 instances.
  - Inputs are gated so the write pulse occurs only during a prog=0 rising-edge write.
  - Outputs are re-inverted to recover the true data.

Test Plan:
- Reset: clr=1 -> aval=0, bval=0, marval=0, cf=0, zf=0 immediately, without a clock edge.
- Program load: prog=0, write 8'h1E @0, 8'h2F @1, 8'hE0 @2, 8'h07 @14, 8'h05 @15 -> bus equals sw_dat each step; marval tracks sw_mar.
- Readback: after program load, set prog=1 with MAR=14 -> bus=8'h07; pulse ai -> aval=8'h07.
- Add: A=8'h07, B=8'h05, su=0, eo=1, fi=1, one clock -> aluval=8'h0C, cf=0, zf=0.
- Subtract to zero: A=8'h05, B=8'h05, su=1, fi=1 -> aluval=8'h00, cf=1, zf=1.
- Wrap and priority: A=8'hFF, B=8'h01, add -> aluval=8'h00, cf=1, zf=1; with ao=1 and eo=1 -> bus=aval. With COMPUTER_CONTENTION_CHK_EN defined, that ao=1/eo=1 edge (prog=1) reports an $error.
